// File: rtl/ahb_dma_master.sv
// ahb_dma_master: AHB-Lite master that streams 128-bit blocks from src memory to the AES core and writes results to dst.
// Latency: per 16-byte block, 5 cycles read burst + 1 GIVE + 1 WAIT_RES + 5 cycles write burst at zero wait (plus AES time).
// Backpressure: hready=0 freezes address/control/hwdata; blk_out_valid holds until blk_out_ready; blk_in accepted only in WAIT_RES.
//
// Ports:
//   hclk, hreset                 clock, asynchronous active-high reset
//   start, src_addr, dst_addr,   job request (one cycle, ignored unless idle) and its
//   size_bytes                   parameters (16-byte aligned, length a nonzero multiple of 16)
//   haddr, htrans, hwrite,       AHB-Lite master address/control (INCR4 word bursts)
//   hsize, hburst, hprot
//   hwdata / hrdata              write / read data
//   hready, hresp                slave handshake and OKAY/ERROR response
//   blk_out*, blk_in*            valid/ready block interface to and from the AES core
//   busy, done, err              job status; err is meaningful with done and held until the next job

module ahb_dma_master #(
   parameter int         SIZE_W    = 32,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              start,
   input  logic [31:0]       src_addr,
   input  logic [31:0]       dst_addr,
   input  logic [SIZE_W-1:0] size_bytes,
   output logic [31:0]       haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [3:0]        hprot,
   output logic [31:0]       hwdata,
   input  logic [31:0]       hrdata,
   input  logic              hready,
   input  logic              hresp,
   output logic [127:0]      blk_out,
   output logic              blk_out_valid,
   input  logic              blk_out_ready,
   input  logic [127:0]      blk_in,
   input  logic              blk_in_valid,
   output logic              blk_in_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_GIVE,
      S_WAIT_RES,
      S_WR,
      S_FIN
   } state_t;

   state_t            r_state;
   logic [31:0]       r_haddr;
   logic [1:0]        r_htrans;
   logic              r_hwrite;
   logic [31:0]       r_hwdata;
   // One block register serves both directions: it holds the read block
   // while offered to the AES core, then the AES result while it is written.
   logic [127:0]      r_blk;
   logic              r_blk_out_valid;
   logic              r_blk_in_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [31:0]       r_src;
   logic [31:0]       r_dst;
   logic [SIZE_W-1:0] r_rem;
   logic [1:0]        r_acnt;   // address beats accepted in the current burst
   logic [1:0]        r_dcnt;   // data beats completed in the current burst
   logic              r_dph;    // a data phase is on the bus this cycle

   logic              w_acc;
   logic              w_bad;
   logic              w_last_blk;
   logic [6:0]        w_rsel;
   logic [6:0]        w_wsel;

   // An address phase completes whenever the slave is ready and we drive a transfer.
   assign w_acc      = hready && (r_htrans != HT_IDLE);
   assign w_bad      = (size_bytes == '0) || (size_bytes[3:0] != 4'd0) ||
                       (src_addr[3:0] != 4'd0) || (dst_addr[3:0] != 4'd0);
   assign w_last_blk = (r_rem == SIZE_W'(16));
   // Beat k lives at bits [127-32k -: 32], i.e. base offset 96-32k.
   assign w_rsel     = 7'd96 - {r_dcnt, 5'd0};
   assign w_wsel     = 7'd96 - {r_acnt, 5'd0};

   assign haddr         = r_haddr;
   assign htrans        = r_htrans;
   assign hwrite        = r_hwrite;
   assign hsize         = 3'b010;
   assign hburst        = 3'b011;
   assign hprot         = HPROT_VAL;
   assign hwdata        = r_hwdata;
   assign blk_out       = r_blk;
   assign blk_out_valid = r_blk_out_valid;
   assign blk_in_ready  = r_blk_in_ready;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state         <= S_IDLE;
         r_haddr         <= '0;
         r_htrans        <= HT_IDLE;
         r_hwrite        <= 1'b0;
         r_hwdata        <= '0;
         r_blk           <= '0;
         r_blk_out_valid <= 1'b0;
         r_blk_in_ready  <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_err           <= 1'b0;
         r_src           <= '0;
         r_dst           <= '0;
         r_rem           <= '0;
         r_acnt          <= '0;
         r_dcnt          <= '0;
         r_dph           <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src <= src_addr;
                  r_dst <= dst_addr;
                  r_rem <= size_bytes;
                  if (w_bad) begin
                     // Rejected job: report at once without touching the bus.
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_err    <= 1'b0;
                     r_busy   <= 1'b1;
                     r_htrans <= HT_NONSEQ;
                     r_haddr  <= src_addr;
                     r_hwrite <= 1'b0;
                     r_acnt   <= '0;
                     r_dcnt   <= '0;
                     r_dph    <= 1'b0;
                     r_state  <= S_RD;
                  end
               end
            end

            S_RD, S_WR: begin
               if (r_dph && hresp) begin
                  // ERROR response: cancel the pending address phase on the
                  // first (hready=0) cycle, finish the job when it completes.
                  r_htrans <= HT_IDLE;
                  if (hready) begin
                     r_hwrite <= 1'b0;
                     r_dph    <= 1'b0;
                     r_acnt   <= '0;
                     r_dcnt   <= '0;
                     r_err    <= 1'b1;
                     r_done   <= 1'b1;
                     r_state  <= S_FIN;
                  end
               end else begin
                  if (w_acc) begin
                     r_dph  <= 1'b1;
                     r_acnt <= r_acnt + 2'd1;
                     // Write data follows its address phase by one cycle.
                     if (r_state == S_WR) begin
                        r_hwdata <= r_blk[w_wsel +: 32];
                     end
                     if (r_acnt == 2'd3) begin
                        r_htrans <= HT_IDLE;
                     end else begin
                        r_htrans <= HT_SEQ;
                        r_haddr  <= r_haddr + 32'd4;
                     end
                  end else if (hready) begin
                     r_dph <= 1'b0;
                  end

                  if (hready && r_dph) begin
                     r_dcnt <= r_dcnt + 2'd1;
                     if (r_state == S_RD) begin
                        r_blk[w_rsel +: 32] <= hrdata;
                     end
                     if (r_dcnt == 2'd3) begin
                        if (r_state == S_RD) begin
                           r_blk_out_valid <= 1'b1;
                           r_state         <= S_GIVE;
                        end else begin
                           r_rem    <= r_rem - SIZE_W'(16);
                           r_src    <= r_src + 32'd16;
                           r_dst    <= r_dst + 32'd16;
                           r_hwrite <= 1'b0;
                           if (w_last_blk) begin
                              r_done  <= 1'b1;
                              r_state <= S_FIN;
                           end else begin
                              // Next read burst starts without an idle bubble.
                              r_htrans <= HT_NONSEQ;
                              r_haddr  <= r_src + 32'd16;
                              r_state  <= S_RD;
                           end
                        end
                     end
                  end
               end
            end

            S_GIVE: begin
               if (blk_out_ready) begin
                  r_blk_out_valid <= 1'b0;
                  r_blk_in_ready  <= 1'b1;
                  r_state         <= S_WAIT_RES;
               end
            end

            S_WAIT_RES: begin
               if (blk_in_valid) begin
                  r_blk          <= blk_in;
                  r_blk_in_ready <= 1'b0;
                  r_htrans       <= HT_NONSEQ;
                  r_haddr        <= r_dst;
                  r_hwrite       <= 1'b1;
                  r_acnt         <= '0;
                  r_dcnt         <= '0;
                  r_dph          <= 1'b0;
                  r_state        <= S_WR;
               end
            end

            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
